// File: rtl/pool_stream_sequencer_if.sv
// rtl/pool_stream_sequencer_if.sv - host/datapath signal bundle for the pooling frame sequencer
interface pool_stream_sequencer_if #(
    parameter int V_BITW = 5,
    parameter int H_BITW = 6
);
    logic                     start;
    logic                     hold;
    logic                     pool_enable;
    logic                     out_enable;
    logic [V_BITW-1:0]        out_vcnt;
    logic [H_BITW-1:0]        out_hcnt;
    logic                     busy;
    logic                     done;
    logic                     error;
    logic [V_BITW+H_BITW-1:0] pool_count;

    modport master (
        output start, hold, pool_enable,
        input  out_enable, out_vcnt, out_hcnt, busy, done, error, pool_count
    );

    modport slave (
        input  start, hold, pool_enable,
        output out_enable, out_vcnt, out_hcnt, busy, done, error, pool_count
    );
endinterface

// File: rtl/pool_stream_sequencer.sv
// rtl/pool_stream_sequencer.sv - raster coordinate generator, pipeline drain and pooled-output audit for one frame
module pool_stream_sequencer #(
    parameter int W_WIDTH      = 64,
    parameter int W_HEIGHT     = 32,
    parameter int LEVEL        = 0,
    parameter int FLUSH_CYCLES = 8,
    parameter int V_BITW       = $clog2(W_HEIGHT),
    parameter int H_BITW       = $clog2(W_WIDTH)
) (
    input  logic                  clock,
    input  logic                  n_rst,
    pool_stream_sequencer_if.slave bus
);
    localparam int C_BITW = V_BITW + H_BITW;
    localparam int F_BITW = $clog2(FLUSH_CYCLES + 1);
    localparam logic [C_BITW-1:0] EXPECTED =
        C_BITW'((W_WIDTH >> (LEVEL + 1)) * (W_HEIGHT >> (LEVEL + 1)));
    localparam logic [H_BITW-1:0] H_LAST = H_BITW'(W_WIDTH - 1);
    localparam logic [V_BITW-1:0] V_LAST = V_BITW'(W_HEIGHT - 1);
    localparam logic [F_BITW-1:0] F_LAST = F_BITW'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

    state_t              r_state, w_state;
    logic                r_en, w_en;
    logic [H_BITW-1:0]   r_hcnt, w_hcnt;
    logic [V_BITW-1:0]   r_vcnt, w_vcnt;
    logic                r_busy, w_busy;
    logic                r_done, w_done;
    logic                r_error, w_error;
    logic [C_BITW-1:0]   r_count, w_count;
    logic [C_BITW-1:0]   w_count_inc;
    logic [F_BITW-1:0]   r_flush, w_flush;

    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= S_IDLE;
            r_en    <= 1'b0;
            r_hcnt  <= '0;
            r_vcnt  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_count <= '0;
            r_flush <= '0;
        end else begin
            r_state <= w_state;
            r_en    <= w_en;
            r_hcnt  <= w_hcnt;
            r_vcnt  <= w_vcnt;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_error <= w_error;
            r_count <= w_count;
            r_flush <= w_flush;
        end
    end

    // The registered coordinate is the one presented (r_en=1) or the next one
    // waiting behind a hold bubble (r_en=0); it advances only once consumed.
    always_comb begin
        w_state     = r_state;
        w_en        = 1'b0;
        w_hcnt      = r_hcnt;
        w_vcnt      = r_vcnt;
        w_busy      = r_busy;
        w_done      = 1'b0;
        w_error     = r_error;
        w_count     = r_count;
        w_flush     = r_flush;
        w_count_inc = (r_count == '1) ? r_count : r_count + 1'b1;

        case (r_state)
            S_IDLE: begin
                // a start coinciding with the done pulse is deliberately dropped
                if (bus.start && !r_done) begin
                    w_state = S_RUN;
                    w_en    = 1'b1;
                    w_hcnt  = '0;
                    w_vcnt  = '0;
                    w_busy  = 1'b1;
                    w_count = '0;
                    w_error = 1'b0;
                    w_flush = '0;
                end
                if (bus.pool_enable) begin
                    w_error = 1'b1;
                end
            end
            S_RUN: begin
                if (bus.pool_enable) begin
                    w_count = w_count_inc;
                end
                if (r_en && r_hcnt == H_LAST && r_vcnt == V_LAST) begin
                    w_state = S_FLUSH;
                    w_flush = '0;
                end else begin
                    w_en = !bus.hold;
                    if (r_en) begin
                        if (r_hcnt == H_LAST) begin
                            w_hcnt = '0;
                            w_vcnt = r_vcnt + 1'b1;
                        end else begin
                            w_hcnt = r_hcnt + 1'b1;
                        end
                    end
                end
            end
            S_FLUSH: begin
                if (bus.pool_enable) begin
                    w_count = w_count_inc;
                end
                if (r_flush == F_LAST) begin
                    w_state = S_IDLE;
                    w_done  = 1'b1;
                    w_busy  = 1'b0;
                    w_flush = '0;
                    if (w_count != EXPECTED) begin
                        w_error = 1'b1;
                    end
                end else begin
                    w_flush = r_flush + 1'b1;
                end
            end
            default: begin
                w_state = S_IDLE;
                w_busy  = 1'b0;
            end
        endcase
    end

    assign bus.out_enable = r_en;
    assign bus.out_hcnt   = r_hcnt;
    assign bus.out_vcnt   = r_vcnt;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.error      = r_error;
    assign bus.pool_count = r_count;
endmodule

// File: tb/tb_pool_stream_sequencer.sv
// tb/tb_pool_stream_sequencer.sv - randomized self-checking bench for pool_stream_sequencer
module tb_pool_stream_sequencer;
    localparam int W0 = 64;
    localparam int H0 = 32;
    localparam int W1 = 16;
    localparam int H1 = 8;
    localparam int FL = 8;

    logic clock = 1'b0;
    logic n_rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    pool_stream_sequencer_if #(.V_BITW(5), .H_BITW(6)) b0 ();
    pool_stream_sequencer_if #(.V_BITW(3), .H_BITW(4)) b1 ();

    pool_stream_sequencer #(.W_WIDTH(W0), .W_HEIGHT(H0), .LEVEL(0), .FLUSH_CYCLES(FL))
        dut0 (.clock(clock), .n_rst(n_rst), .bus(b0));
    pool_stream_sequencer #(.W_WIDTH(W1), .W_HEIGHT(H1), .LEVEL(1), .FLUSH_CYCLES(FL))
        dut1 (.clock(clock), .n_rst(n_rst), .bus(b1));

    always #5 clock = ~clock;

    // Runs one frame on dut0 with a 4-cycle loopback datapath model.
    // suppress selects which pooled strobe (by order) is dropped; -1 drops none.
    task automatic frame0(input bit use_holds, input int suppress, input bit spam,
                          output int n_en, output int n_bad, output int t_done,
                          output int n_hold, output bit busy_ok);
        bit hold_at[0:2299];
        bit pipe[4];
        bit hit, fin;
        int idx, hits, placed, c;
        n_en = 0; n_bad = 0; t_done = -1; n_hold = 0; busy_ok = 1'b1;
        idx = 0; hits = 0; fin = 1'b0; placed = 0;
        for (int i = 0; i < 2300; i++) hold_at[i] = 1'b0;
        for (int i = 0; i < 4; i++) pipe[i] = 1'b0;
        if (use_holds) begin
            for (int i = 1000; i < 1005; i++) hold_at[i] = 1'b1;
            while (placed < 10) begin
                c = $urandom_range(100, 1900);
                if (!hold_at[c] && (c < 998 || c > 1006) && !hold_at[c-1] && !hold_at[c+1]) begin
                    hold_at[c] = 1'b1;
                    placed++;
                end
            end
        end
        @(posedge clock); #1;
        b0.start = 1'b1;
        @(posedge clock); #1;
        b0.start = 1'b0;
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            if (cyc > 0) begin
                @(posedge clock); #1;
            end
            hit = 1'b0;
            if (b0.out_enable === 1'b1) begin
                if (b0.out_vcnt !== 5'(idx / W0) || b0.out_hcnt !== 6'(idx % W0)) n_bad++;
                hit = (((idx % W0) % 2) == 1) && (((idx / W0) % 2) == 1);
                if (hit) begin
                    if (hits == suppress) hit = 1'b0;
                    hits++;
                end
                idx++;
                n_en++;
            end
            if (b0.done === 1'b1) begin
                t_done = cyc;
                fin = 1'b1;
                if (b0.busy !== 1'b0) busy_ok = 1'b0;
            end else if (b0.busy !== 1'b1) begin
                busy_ok = 1'b0;
            end
            b0.pool_enable = pipe[3];
            pipe[3] = pipe[2]; pipe[2] = pipe[1]; pipe[1] = pipe[0]; pipe[0] = hit;
            b0.hold = (cyc < 2300) ? hold_at[cyc] : 1'b0;
            if (b0.hold && idx < W0 * H0) n_hold++;
            b0.start = spam && (cyc == 500 || cyc == 2050);
        end
        b0.hold = 1'b0;
        b0.pool_enable = 1'b0;
        b0.start = 1'b0;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({b0.out_enable, b0.busy, b0.done, b0.error} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags0 got=%b exp=0000", {b0.out_enable, b0.busy, b0.done, b0.error});
        end
        checks++;
        if (b0.out_vcnt !== 5'd0 || b0.out_hcnt !== 6'd0 || b0.pool_count !== 11'd0) begin
            errors++;
            $display("FAIL reset_counts0 got v=%0d h=%0d pc=%0d exp=0", b0.out_vcnt, b0.out_hcnt, b0.pool_count);
        end
        checks++;
        if ({b1.out_enable, b1.busy, b1.done, b1.error, b1.out_vcnt, b1.out_hcnt, b1.pool_count} !== 0) begin
            errors++;
            $display("FAIL reset_all1 got en=%b busy=%b pc=%0d exp=0", b1.out_enable, b1.busy, b1.pool_count);
        end
        n_rst = 1'b1;
        @(posedge clock); #1;
        checks++;
        if (b0.busy !== 1'b0 || b0.out_enable !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got busy=%b en=%b exp=0", b0.busy, b0.out_enable);
        end
    endtask

    task automatic test_basic_frame();
        int n_en, n_bad, t_done, n_hold;
        bit busy_ok;
        frame0(1'b0, -1, 1'b0, n_en, n_bad, t_done, n_hold, busy_ok);
        checks++;
        if (n_en !== W0 * H0) begin errors++; $display("FAIL basic_enables got=%0d exp=%0d", n_en, W0 * H0); end
        checks++;
        if (n_bad !== 0) begin errors++; $display("FAIL basic_raster got=%0d bad exp=0", n_bad); end
        checks++;
        if (t_done !== W0 * H0 + FL) begin errors++; $display("FAIL basic_done_time got=%0d exp=%0d", t_done, W0 * H0 + FL); end
        checks++;
        if (b0.pool_count !== 11'((W0 / 2) * (H0 / 2)) || b0.error !== 1'b0) begin
            errors++;
            $display("FAIL basic_count got pc=%0d err=%b exp pc=%0d err=0", b0.pool_count, b0.error, (W0 / 2) * (H0 / 2));
        end
        checks++;
        if (busy_ok !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b exp=1", busy_ok); end
        @(posedge clock); #1;
        checks++;
        if (b0.done !== 1'b0 || b0.out_enable !== 1'b0 || b0.out_vcnt !== 5'(H0 - 1) || b0.out_hcnt !== 6'(W0 - 1)) begin
            errors++;
            $display("FAIL basic_after got done=%b en=%b v=%0d h=%0d exp 0 0 %0d %0d",
                     b0.done, b0.out_enable, b0.out_vcnt, b0.out_hcnt, H0 - 1, W0 - 1);
        end
    endtask

    task automatic test_hold_bubbles();
        int n_en, n_bad, t_done, n_hold;
        bit busy_ok;
        frame0(1'b1, -1, 1'b0, n_en, n_bad, t_done, n_hold, busy_ok);
        checks++;
        if (n_hold !== 15) begin errors++; $display("FAIL hold_plan got=%0d exp=15", n_hold); end
        checks++;
        if (n_en !== W0 * H0 || n_bad !== 0) begin
            errors++;
            $display("FAIL hold_raster got en=%0d bad=%0d exp en=%0d bad=0", n_en, n_bad, W0 * H0);
        end
        checks++;
        if (t_done !== W0 * H0 + FL + n_hold) begin
            errors++;
            $display("FAIL hold_done_time got=%0d exp=%0d", t_done, W0 * H0 + FL + n_hold);
        end
        checks++;
        if (b0.error !== 1'b0 || b0.pool_count !== 11'd512) begin
            errors++;
            $display("FAIL hold_result got err=%b pc=%0d exp err=0 pc=512", b0.error, b0.pool_count);
        end
    endtask

    task automatic test_count_mismatch();
        int n_en, n_bad, t_done, n_hold;
        bit busy_ok;
        frame0(1'b0, $urandom_range(0, 511), 1'b0, n_en, n_bad, t_done, n_hold, busy_ok);
        checks++;
        if (b0.pool_count !== 11'd511 || b0.error !== 1'b1 || t_done !== W0 * H0 + FL) begin
            errors++;
            $display("FAIL mismatch_result got pc=%0d err=%b t=%0d exp pc=511 err=1 t=%0d",
                     b0.pool_count, b0.error, t_done, W0 * H0 + FL);
        end
        b0.start = 1'b1;
        @(posedge clock); #1;
        b0.start = 1'b0;
        checks++;
        if (b0.busy !== 1'b0 || b0.error !== 1'b1) begin
            errors++;
            $display("FAIL start_at_done got busy=%b err=%b exp busy=0 err=1", b0.busy, b0.error);
        end
        frame0(1'b0, -1, 1'b0, n_en, n_bad, t_done, n_hold, busy_ok);
        checks++;
        if (b0.error !== 1'b0 || b0.pool_count !== 11'd512 || n_bad !== 0) begin
            errors++;
            $display("FAIL mismatch_recover got err=%b pc=%0d bad=%0d exp err=0 pc=512 bad=0", b0.error, b0.pool_count, n_bad);
        end
    endtask

    task automatic test_spurious_and_busy_start();
        int n_en, n_bad, t_done, n_hold;
        bit busy_ok;
        @(posedge clock); #1;
        b0.pool_enable = 1'b1;
        @(posedge clock); #1;
        b0.pool_enable = 1'b0;
        checks++;
        if (b0.error !== 1'b1 || b0.pool_count !== 11'd512 || b0.busy !== 1'b0) begin
            errors++;
            $display("FAIL spurious got err=%b pc=%0d busy=%b exp err=1 pc=512 busy=0", b0.error, b0.pool_count, b0.busy);
        end
        frame0(1'b0, -1, 1'b1, n_en, n_bad, t_done, n_hold, busy_ok);
        checks++;
        if (n_en !== W0 * H0 || n_bad !== 0 || t_done !== W0 * H0 + FL) begin
            errors++;
            $display("FAIL busy_start got en=%0d bad=%0d t=%0d exp en=%0d bad=0 t=%0d",
                     n_en, n_bad, t_done, W0 * H0, W0 * H0 + FL);
        end
        checks++;
        if (b0.error !== 1'b0 || busy_ok !== 1'b1) begin
            errors++;
            $display("FAIL busy_start_flags got err=%b busy_ok=%b exp err=0 busy_ok=1", b0.error, busy_ok);
        end
    endtask

    task automatic test_reset_mid_frame();
        int n_en, n_bad, t_done, n_hold;
        bit busy_ok, found, seen_done;
        found = 1'b0;
        seen_done = 1'b0;
        @(posedge clock); #1;
        b0.start = 1'b1;
        @(posedge clock); #1;
        b0.start = 1'b0;
        for (int g = 0; g < 1000 && !found; g++) begin
            if (b0.out_enable === 1'b1 && b0.out_vcnt === 5'd10 && b0.out_hcnt === 6'd5) found = 1'b1;
            else begin
                @(posedge clock); #1;
            end
        end
        checks++;
        if (!found) begin errors++; $display("FAIL midreset_reach got=0 exp=1"); end
        #2 n_rst = 1'b0;
        #1;
        checks++;
        if ({b0.out_enable, b0.busy, b0.done, b0.error, b0.out_vcnt, b0.out_hcnt, b0.pool_count} !== 0) begin
            errors++;
            $display("FAIL midreset_async got en=%b busy=%b v=%0d h=%0d pc=%0d exp=0",
                     b0.out_enable, b0.busy, b0.out_vcnt, b0.out_hcnt, b0.pool_count);
        end
        for (int i = 0; i < 6; i++) begin
            @(posedge clock); #1;
            if (i == 1) n_rst = 1'b1;
            if (b0.done === 1'b1 || b0.busy === 1'b1) seen_done = 1'b1;
        end
        checks++;
        if (seen_done) begin errors++; $display("FAIL midreset_nodone got=1 exp=0"); end
        frame0(1'b0, -1, 1'b0, n_en, n_bad, t_done, n_hold, busy_ok);
        checks++;
        if (n_en !== W0 * H0 || n_bad !== 0 || t_done !== W0 * H0 + FL || b0.pool_count !== 11'd512 || b0.error !== 1'b0) begin
            errors++;
            $display("FAIL midreset_next got en=%0d bad=%0d t=%0d pc=%0d err=%b exp %0d 0 %0d 512 0",
                     n_en, n_bad, t_done, b0.pool_count, b0.error, W0 * H0, W0 * H0 + FL);
        end
    endtask

    task automatic test_level1();
        bit pipe[4];
        bit hit, fin;
        int idx, n_bad, n_hold, t_done;
        idx = 0; n_bad = 0; n_hold = 0; t_done = -1; fin = 1'b0;
        for (int i = 0; i < 4; i++) pipe[i] = 1'b0;
        @(posedge clock); #1;
        b1.start = 1'b1;
        @(posedge clock); #1;
        b1.start = 1'b0;
        for (int cyc = 0; cyc < 1000 && !fin; cyc++) begin
            if (cyc > 0) begin
                @(posedge clock); #1;
            end
            hit = 1'b0;
            if (b1.out_enable === 1'b1) begin
                if (b1.out_vcnt !== 3'(idx / W1) || b1.out_hcnt !== 4'(idx % W1)) n_bad++;
                hit = (((idx % W1) % 4) == 3) && (((idx / W1) % 4) == 3);
                idx++;
            end
            if (b1.done === 1'b1) begin
                t_done = cyc;
                fin = 1'b1;
            end
            b1.pool_enable = pipe[3];
            pipe[3] = pipe[2]; pipe[2] = pipe[1]; pipe[1] = pipe[0]; pipe[0] = hit;
            b1.hold = ($urandom_range(0, 3) == 0) && !fin;
            if (b1.hold && idx < W1 * H1) n_hold++;
        end
        b1.hold = 1'b0;
        b1.pool_enable = 1'b0;
        checks++;
        if (idx !== W1 * H1 || n_bad !== 0) begin
            errors++;
            $display("FAIL level1_raster got en=%0d bad=%0d exp en=%0d bad=0", idx, n_bad, W1 * H1);
        end
        checks++;
        if (t_done !== W1 * H1 + n_hold + FL) begin
            errors++;
            $display("FAIL level1_done_time got=%0d exp=%0d", t_done, W1 * H1 + n_hold + FL);
        end
        checks++;
        if (b1.pool_count !== 7'((W1 / 4) * (H1 / 4)) || b1.error !== 1'b0) begin
            errors++;
            $display("FAIL level1_count got pc=%0d err=%b exp pc=%0d err=0", b1.pool_count, b1.error, (W1 / 4) * (H1 / 4));
        end
    endtask

    initial begin
        b0.start = 1'b0; b0.hold = 1'b0; b0.pool_enable = 1'b0;
        b1.start = 1'b0; b1.hold = 1'b0; b1.pool_enable = 1'b0;
        test_reset();
        test_basic_frame();
        test_hold_bubbles();
        test_count_mismatch();
        test_spurious_and_busy_start();
        test_reset_mid_frame();
        test_level1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
